// File: rtl/dmem_bridge.sv
// Bridges the core's memory-stage word port onto a byte-wide req/ack SRAM bus.
// Each word moves as little-endian byte beats with a one-cycle return-to-zero gap between them.
module dmem_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [7:0]        ext_wdata,
    input  logic [7:0]        ext_rdata,
    input  logic              ext_ack
);

    localparam int BEATS  = DATA_W / 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP,
        DONE
    } stateT;

    stateT              state;
    logic [BEAT_W-1:0]  beat;
    logic [7:0]         timer;
    logic               opWrite;
    logic [ADDR_W-1:0]  baseAddr;
    logic [DATA_W-1:0]  storeData;
    logic [DATA_W-1:0]  loadBuf;
    logic [DATA_W-1:0]  mergedLoad;
    logic [7:0]         beatByte;
    logic [BEAT_W-1:0]  nextBeat;
    logic               lastBeat;
    logic               timedOut;
    logic               request;

    assign request  = cpu_read | cpu_write;
    assign lastBeat = (beat == BEAT_W'(BEATS - 1));
    assign timedOut = (timer == 8'(TIMEOUT - 1));
    assign nextBeat = beat + BEAT_W'(1);

    // Gated by rst so the pipeline is released immediately while reset is held.
    assign cpu_stall = rst & ((state == BUS) | (state == GAP) | ((state == IDLE) & request));

    // mergedLoad is the read buffer with the current beat's lane replaced by the bus byte;
    // beatByte is the store byte for the current beat.
    always_comb begin
        mergedLoad = loadBuf;
        beatByte   = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat == BEAT_W'(i)) begin
                mergedLoad[8*i +: 8] = ext_rdata;
                beatByte             = storeData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beat      <= '0;
            timer     <= '0;
            opWrite   <= 1'b0;
            baseAddr  <= '0;
            storeData <= '0;
            loadBuf   <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        opWrite   <= cpu_write;
                        baseAddr  <= cpu_addr;
                        storeData <= cpu_wdata;
                        loadBuf   <= '0;
                        beat      <= '0;
                        timer     <= '0;
                        cpu_err   <= 1'b0;
                        ext_req   <= 1'b1;
                        ext_we    <= cpu_write;
                        ext_addr  <= cpu_addr;
                        ext_wdata <= cpu_wdata[7:0];
                        state     <= BUS;
                    end
                end
                BUS: begin
                    if (ext_ack) begin
                        ext_req <= 1'b0;
                        if (!opWrite) begin
                            loadBuf <= mergedLoad;
                        end
                        if (lastBeat) begin
                            if (!opWrite) begin
                                cpu_rdata <= mergedLoad;
                            end
                            state <= DONE;
                        end else begin
                            beat  <= nextBeat;
                            timer <= '0;
                            state <= GAP;
                        end
                    end else if (timedOut) begin
                        // Aborted writes are left partially applied; aborted reads return zero.
                        ext_req <= 1'b0;
                        cpu_err <= 1'b1;
                        if (!opWrite) begin
                            cpu_rdata <= '0;
                        end
                        state <= DONE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                GAP: begin
                    ext_req   <= 1'b1;
                    ext_addr  <= baseAddr + ADDR_W'(beat);
                    ext_wdata <= beatByte;
                    timer     <= '0;
                    state     <= BUS;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: a byte SRAM responder checks every bus beat against
// queued expectations and each access's stall latency, load data and error flag.
module tb_dmem_bridge;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 99;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } BeatRec;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        ext_req;
    logic        ext_we;
    logic [7:0]  ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [7:0]  mem [256];
    BeatRec      beatQ[$];
    int          delayQ[$];
    BeatRec      cur;
    int          curDelay;
    int          waitCnt;
    bit          beatSeen;
    bit          prevAck;
    bit          ackInGap;
    logic [31:0] lastRdata;

    dmem_bridge #(
        .ADDR_W (8),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_read (cpu_read),
        .cpu_write(cpu_write),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .cpu_err  (cpu_err),
        .ext_req  (ext_req),
        .ext_we   (ext_we),
        .ext_addr (ext_addr),
        .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata),
        .ext_ack  (ext_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // SRAM responder: acks each beat after its queued delay and checks beat contents.
    always @(negedge clk) begin
        ext_ack   = 1'b0;
        ext_rdata = 8'h5A;
        if (!rst) begin
            beatSeen = 1'b0;
            prevAck  = 1'b0;
        end else begin
            if (prevAck) begin
                checkOutput("gapReqLow", 32'(ext_req), 32'd0);
            end
            prevAck = 1'b0;
            if (ext_req) begin
                if (!beatSeen) begin
                    beatSeen = 1'b1;
                    waitCnt  = 0;
                    if (beatQ.size() == 0) begin
                        checkOutput("beatExpected", 32'd0, 32'd1);
                        cur      = '{we: ext_we, addr: ext_addr, data: ext_wdata};
                        curDelay = 0;
                    end else begin
                        cur      = beatQ.pop_front();
                        curDelay = delayQ.pop_front();
                        checkOutput("beatWe", 32'(ext_we), 32'(cur.we));
                        checkOutput("beatAddr", 32'(ext_addr), 32'(cur.addr));
                        if (cur.we) begin
                            checkOutput("beatData", 32'(ext_wdata), 32'(cur.data));
                        end
                    end
                end else begin
                    checkOutput("reqStable", 32'(ext_addr), 32'(cur.addr));
                end
                if (waitCnt == curDelay) begin
                    ext_ack  = 1'b1;
                    prevAck  = 1'b1;
                    beatSeen = 1'b0;
                    if (cur.we) begin
                        mem[cur.addr] = cur.data;
                    end else begin
                        ext_rdata = mem[cur.addr];
                    end
                end else begin
                    waitCnt++;
                end
            end else begin
                beatSeen = 1'b0;
                if (ackInGap) begin
                    ext_ack   = 1'b1;
                    ext_rdata = 8'hEE;
                end
            end
        end
    end

    // Issues one access at an IDLE negedge and returns at the negedge of the following IDLE cycle.
    task automatic applyStimulus(input bit wr, input bit both, input logic [7:0] addr,
                                 input logic [31:0] wdata, input int d0, input int d1,
                                 input int d2, input int d3, input bit hold);
        int          dly[4];
        int          expLat;
        int          cnt;
        bit          aborted;
        logic [31:0] expData;
        BeatRec      rec;
        dly     = '{d0, d1, d2, d3};
        expLat  = 1;
        aborted = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!aborted) begin
                rec.we   = wr;
                rec.addr = addr + 8'(i);
                rec.data = wdata[8*i +: 8];
                beatQ.push_back(rec);
                delayQ.push_back(dly[i]);
                if (dly[i] > TIMEOUT - 1) begin
                    aborted = 1'b1;
                    expLat += TIMEOUT;
                end else begin
                    expLat += dly[i] + 1;
                    if (i < 3) expLat += 1;
                end
            end
        end
        if (wr) begin
            expData = lastRdata;
        end else if (aborted) begin
            expData = 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) expData[8*i +: 8] = mem[addr + 8'(i)];
        end

        cpu_write = wr;
        cpu_read  = !wr || both;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
        checkOutput("stallIssue", 32'(cpu_stall), 32'd1);
        cnt = 1;
        @(negedge clk);
        checkOutput("errClearOnAccept", 32'(cpu_err), 32'd0);
        while (cpu_stall && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("stallCycles", 32'(cnt), 32'(expLat));
        checkOutput("doneRdata", cpu_rdata, expData);
        checkOutput("doneErr", 32'(cpu_err), 32'(aborted));
        if (!hold) begin
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
        end
        @(negedge clk);
        checkOutput("noStartAfterDone", 32'(ext_req), 32'd0);
        if (!hold) begin
            checkOutput("idleStall", 32'(cpu_stall), 32'd0);
            checkOutput("rdataHeld", cpu_rdata, expData);
            checkOutput("errHeld", 32'(cpu_err), 32'(aborted));
        end
        lastRdata = expData;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rst       = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ackInGap  = 1'b0;
        lastRdata = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("rstReq", 32'(ext_req), 32'd0);
        checkOutput("rstRdata", cpu_rdata, 32'd0);
        checkOutput("rstErr", 32'(cpu_err), 32'd0);
        checkOutput("rstAddr", 32'(ext_addr), 32'd0);
        checkOutput("rstStall", 32'(cpu_stall), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Zero-wait word write, then a read that wraps the byte address.
        applyStimulus(1'b1, 1'b0, 8'h10, 32'h11223344, 0, 0, 0, 0, 1'b0);
        mem[8'hFE] = 8'hAA;
        mem[8'hFF] = 8'hBB;
        mem[8'h00] = 8'hCC;
        mem[8'h01] = 8'hDD;
        applyStimulus(1'b0, 1'b0, 8'hFE, 32'h0, 0, 0, 0, 0, 1'b0);
        checkOutput("readWrapWord", cpu_rdata, 32'hDDCCBBAA);

        applyStimulus(1'b1, 1'b0, 8'h20, 32'hA5A55A5A, 0, 0, 3, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h20, 32'h0, 0, 0, 3, 0, 1'b0);

        // Timeout on the second beat of a read; the next access clears the flag.
        applyStimulus(1'b0, 1'b0, 8'h40, 32'h0, 0, NEVER, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 1, 0, 2, 0, 1'b0);

        // Spurious acks while idle, in gaps and in DONE must be ignored.
        ackInGap = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idleAckIgnored", 32'(ext_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'hFE, 32'h0, 0, 1, 0, 0, 1'b0);
        ackInGap = 1'b0;

        // Reset pulsed while beat 2 of a write is waiting for its ack.
        beatQ.push_back('{we: 1'b1, addr: 8'h80, data: 8'hBE});
        beatQ.push_back('{we: 1'b1, addr: 8'h81, data: 8'hBA});
        beatQ.push_back('{we: 1'b1, addr: 8'h82, data: 8'hFE});
        delayQ.push_back(0);
        delayQ.push_back(0);
        delayQ.push_back(NEVER);
        cpu_write = 1'b1;
        cpu_addr  = 8'h80;
        cpu_wdata = 32'hCAFEBABE;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(ext_req && ext_addr == 8'h82) && cnt < 50);
        checkOutput("reachedBeat2", 32'(cnt < 50), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midRstReq", 32'(ext_req), 32'd0);
        checkOutput("midRstStall", 32'(cpu_stall), 32'd0);
        checkOutput("midRstWe", 32'(ext_we), 32'd0);
        checkOutput("midRstRdata", cpu_rdata, 32'd0);
        beatQ.delete();
        delayQ.delete();
        lastRdata = 32'd0;
        @(negedge clk);
        cpu_write = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h80, 32'h0, 0, 0, 0, 0, 1'b0);

        // Back-to-back read then write with strobes held through DONE.
        applyStimulus(1'b0, 1'b0, 8'h12, 32'h0, 0, 0, 0, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h12, 32'h0BADF00D, 0, 1, 0, 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'($urandom), 1'($urandom), 8'($urandom), $urandom,
                          $urandom_range(0, 2), $urandom_range(0, 2),
                          $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end
        checkOutput("queueDrained", 32'(beatQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
